// File: rtl/hacd_pkg.sv
// Shared types and constants for the HAWK read-channel arbiter.
package hacd_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ISSUE  = 2'd1,
    RD_WAIT_R = 2'd2
  } rd_arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int RD_REQ_LKUP = 0;
  localparam int RD_REQ_CMP  = 1;
  localparam int RD_REQ_DCMP = 2;

  // AXI arsize encoding for a full-width beat.
  function automatic int axi_size(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/hawk_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module hawk_rr_pick
  import hacd_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_valid
);

  int idx;

  always_comb begin
    grant     = rr_ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hawk_rd_arb.sv
// Single-outstanding AXI4 read arbiter: round-robin AR grant, R beats steered to the owner,
// sticky rid/timeout error flags.
module hawk_rd_arb
  import hacd_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 512,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int PTR_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [ID_W-1:0]           m_arid,
  output logic [1:0]                m_arburst,
  output logic [2:0]                m_arsize,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic [ID_W-1:0]           m_rid,
  output logic                      busy,
  output logic [PTR_W-1:0]          owner,
  output logic                      rid_err,
  output logic                      timeout_err
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // AR: m_arvalid holds with a stable payload until m_arready; the owner's
  // req_arready pulses in that same cycle. R: owner's req_rready is m_rready.

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

  rd_arb_state_t     state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  owner_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [TMR_W-1:0]  timer_q;
  logic              rid_err_q;
  logic              timeout_err_q;

  logic [PTR_W-1:0]  pick_grant;
  logic              pick_any;
  logic              ar_fire;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [7:0]        len_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_araddr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_arlen[g*8 +: 8];
  end

  hawk_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req      (req_arvalid),
    .rr_ptr   (rr_ptr_q),
    .grant    (pick_grant),
    .any_valid(pick_any)
  );

  always_comb begin
    state_d     = state_q;
    m_arvalid   = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    m_rready    = 1'b0;
    ar_fire     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (pick_any) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          ar_fire              = 1'b1;
          req_arready[owner_q] = 1'b1;
          state_d              = RD_WAIT_R;
        end
      end
      RD_WAIT_R: begin
        req_rvalid[owner_q] = m_rvalid;
        m_rready            = req_rready[owner_q];
        if (m_rvalid && req_rready[owner_q] && m_rlast) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RD_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      timer_q       <= '0;
      rid_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_IDLE && pick_any) begin
        owner_q  <= pick_grant;
        araddr_q <= addr_arr[pick_grant];
        arlen_q  <= len_arr[pick_grant];
      end
      if (ar_fire) begin
        rr_ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        timer_q  <= '0;
      end
      // Timer saturates; after a timeout the FSM keeps waiting until reset.
      if (state_q == RD_WAIT_R) begin
        if (timer_q != TMR_MAX) timer_q <= timer_q + 1'b1;
        else                    timeout_err_q <= 1'b1;
      end
      // A beat outside WAIT_R is never accepted, so it is always a stray.
      if (m_rvalid && (state_q != RD_WAIT_R || m_rid != ID_W'(owner_q)))
        rid_err_q <= 1'b1;
    end
  end

  assign m_araddr    = araddr_q;
  assign m_arlen     = arlen_q;
  assign m_arid      = ID_W'(owner_q);
  assign m_arburst   = AXI_BURST_INCR;
  assign m_arsize    = 3'(axi_size(DATA_W));
  assign rdata       = m_rdata;
  assign rresp       = m_rresp;
  assign rlast       = m_rlast;
  assign busy        = (state_q != RD_IDLE);
  assign owner       = owner_q;
  assign rid_err     = rid_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hawk_rd_arb.sv
// Self-checking bench for hawk_rd_arb: directed scenarios plus randomized traffic
// against a round-robin reference model and an expected-beat scoreboard.
module tb_hawk_rd_arb;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int ID_W    = 4;
  localparam int TMO     = 16;
  localparam int EW      = 2 + 1 + 2 + DATA_W;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic [NUM_REQ-1:0]        req_arvalid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr = '0;
  logic [NUM_REQ*8-1:0]      req_arlen = '0;
  logic [NUM_REQ-1:0]        req_arready;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rready = '0;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      m_arvalid;
  logic                      m_arready = 1'b0;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic [ID_W-1:0]           m_arid;
  logic [1:0]                m_arburst;
  logic [2:0]                m_arsize;
  logic                      m_rvalid = 1'b0;
  logic                      m_rready;
  logic [DATA_W-1:0]         m_rdata = '0;
  logic [1:0]                m_rresp = '0;
  logic                      m_rlast = 1'b0;
  logic [ID_W-1:0]           m_rid = '0;
  logic                      busy;
  logic [1:0]                owner;
  logic                      rid_err;
  logic                      timeout_err;

  hawk_rd_arb #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_arburst(m_arburst), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .busy(busy), .owner(owner), .rid_err(rid_err), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model state ----------------
  int               n_cmp = 0;
  int               n_bad = 0;
  logic             pend_v    [NUM_REQ];
  logic [ADDR_W-1:0] pend_addr [NUM_REQ];
  logic [7:0]       pend_len  [NUM_REQ];
  int               rr_m = 0;
  logic             rid_m = 1'b0;
  logic             tmo_m = 1'b0;
  logic [EW-1:0]    exp_q [$];
  int               grant_log [$];
  int               exp_order [4] = '{0, 1, 2, 0};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[31:0] ^ 32'hC0DE_F00D, ~a[31:0]};
  endfunction

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int model_pick();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_v[(rr_m + i) % NUM_REQ]) return (rr_m + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    req_arvalid[i]               = 1'b1;
    req_araddr[i*ADDR_W +: ADDR_W] = a;
    req_arlen[i*8 +: 8]          = l;
    pend_v[i]    = 1'b1;
    pend_addr[i] = a;
    pend_len[i]  = l;
  endtask

  // One full transaction from IDLE: AR with optional stall, then the R burst.
  task automatic run_txn(input int ar_stall, input int drop_at, input int gap_max,
                         input int rr_mode, input int bad_beat, input logic [1:0] resp_seed);
    int own, cyc, wcyc, nb, gap;
    logic done, tog;
    logic [ADDR_W-1:0] ea, s_addr;
    logic [7:0] el, s_len;
    logic [EW-1:0] got_e, exp_e;
    logic [NUM_REQ-1:0] vec;
    own = model_pick();
    check_eq("model_has_req", (own >= 0), 1'b1);
    if (own < 0) return;
    ea = pend_addr[own];
    el = pend_len[own];
    cyc = 0;
    while (!m_arvalid && cyc < 8) begin
      tick();
      cyc++;
    end
    check_eq("ar_latency", cyc, 1);
    for (int k = 0; k < ar_stall; k++) begin
      if (k == drop_at) req_arvalid[own] = 1'b0;
      m_arready = 1'b0;
      #1;
      check_eq("ar_hold_valid", m_arvalid, 1'b1);
      check_eq("ar_hold_addr", m_araddr, ea);
      check_eq("ar_hold_len", m_arlen, el);
      check_eq("ar_no_pulse", req_arready, 0);
      tick();
    end
    m_arready = 1'b1;
    #1;
    vec = '0;
    vec[own] = 1'b1;
    check_eq("ar_valid", m_arvalid, 1'b1);
    check_eq("ar_addr", m_araddr, ea);
    check_eq("ar_len", m_arlen, el);
    check_eq("ar_id", m_arid, own);
    check_eq("ar_burst", m_arburst, 2'b01);
    check_eq("ar_size", m_arsize, 3'd3);
    check_eq("ar_pulse", req_arready, vec);
    check_eq("busy_issue", busy, 1'b1);
    check_eq("owner", owner, own);
    s_addr = m_araddr;
    s_len  = m_arlen;
    for (int b = 0; b <= int'(el); b++)
      exp_q.push_back({own[1:0], (b == int'(el)), resp_seed ^ b[1:0], mem_word(ea + ADDR_W'(b * 8))});
    grant_log.push_back(own);
    tick();
    m_arready = 1'b0;
    req_arvalid[own] = 1'b0;
    pend_v[own] = 1'b0;
    rr_m = (own + 1) % NUM_REQ;
    #1;
    check_eq("ar_pulse_gone", req_arready, 0);
    wcyc = 0;
    nb   = 0;
    tog  = 1'b1;
    for (int b = 0; b <= int'(s_len); b++) begin
      gap = $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        m_rvalid   = 1'b0;
        req_rready = NUM_REQ'($urandom);
        #1;
        check_eq("rv_gap", req_rvalid, 0);
        check_eq("rr_mirror_gap", m_rready, req_rready[own]);
        tick();
        wcyc++;
      end
      m_rvalid = 1'b1;
      m_rdata  = mem_word(s_addr + ADDR_W'(b * 8));
      m_rresp  = resp_seed ^ b[1:0];
      m_rlast  = (b == int'(s_len));
      m_rid    = (b == bad_beat) ? ID_W'((own + 1) % NUM_REQ) : ID_W'(own);
      if (b == bad_beat) rid_m = 1'b1;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 16) begin
        req_rready = NUM_REQ'($urandom);
        if (rr_mode == 1) begin
          req_rready[own] = tog;
          tog = ~tog;
        end else if (cyc >= 1) begin
          req_rready[own] = 1'b1;
        end
        #1;
        check_eq("rv_route", req_rvalid, vec);
        check_eq("rr_mirror", m_rready, req_rready[own]);
        for (int k = 0; k < NUM_REQ; k++) begin
          if (req_rvalid[k] && req_rready[k]) begin
            got_e = {k[1:0], rlast, rresp, rdata};
            check_eq("beat_expected", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
              exp_e = exp_q.pop_front();
              check_eq("beat", got_e, exp_e);
            end
            nb++;
            done = 1'b1;
          end
        end
        tick();
        wcyc++;
        cyc++;
      end
      check_eq("beat_accepted", done, 1'b1);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rid    = '0;
    if (wcyc >= TMO) tmo_m = 1'b1;
    #1;
    check_eq("n_beats", nb, int'(el) + 1);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("busy_done", busy, 1'b0);
    check_eq("rid_err", rid_err, rid_m);
    check_eq("timeout_err", timeout_err, tmo_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_owner"}, owner, 0);
    check_eq({tag, "_arvalid"}, m_arvalid, 1'b0);
    check_eq({tag, "_arready"}, req_arready, 0);
    check_eq({tag, "_rvalid"}, req_rvalid, 0);
    check_eq({tag, "_rready"}, m_rready, 1'b0);
    check_eq({tag, "_rid_err"}, rid_err, 1'b0);
    check_eq({tag, "_tmo_err"}, timeout_err, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_v[i] = 1'b0;
      pend_addr[i] = '0;
      pend_len[i] = '0;
    end
    m_rvalid   = 1'b1;
    req_rready = '1;
    #3;
    check_reset_outputs("reset");
    m_rvalid   = 1'b0;
    req_rready = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Round-robin order with all three requesting from a fresh pointer.
    set_req(0, 64'h0000_0000_0000_0100, 8'd0);
    set_req(1, 64'h0000_0000_0000_0200, 8'd1);
    set_req(2, 64'h0000_0000_0000_0300, 8'd0);
    run_txn(0, -1, 0, 0, -1, 2'b00);
    set_req(0, 64'h0000_0000_0000_0400, 8'd0);
    run_txn(0, -1, 0, 0, -1, 2'b00);
    set_req(1, 64'h0000_0000_0000_0500, 8'd0);
    run_txn(0, -1, 0, 0, -1, 2'b00);
    run_txn(0, -1, 0, 0, -1, 2'b00);
    for (int i = 0; i < 4; i++) check_eq("rr_order", grant_log[i], exp_order[i]);

    // Requester 1 alone, single beat, immediate m_arready.
    set_req(1, 64'h0000_0000_0000_1000, 8'd0);
    run_txn(0, -1, 0, 0, -1, 2'b00);

    // AR stalled 5 cycles, requester 0 drops arvalid mid-stall.
    set_req(0, 64'h0000_0000_2000_0040, 8'd2);
    run_txn(5, 2, 0, 0, -1, 2'b01);

    // Four-beat burst with owner rready toggling 1,0,1,...
    set_req(2, 64'h0000_0000_0000_3000, 8'd3);
    run_txn(0, -1, 0, 1, -1, 2'b00);

    // Wrong rid on a beat for owner 1; SLVERR passes through.
    set_req(1, 64'h0000_0000_0000_4000, 8'd0);
    run_txn(1, -1, 0, 0, 0, 2'b10);

    // Randomized traffic; pending requests persist across transactions.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1))
          set_req(i, {$urandom, $urandom_range(0, 4095) << 3}, 8'($urandom_range(0, 2)));
      end
      if (model_pick() < 0)
        set_req($urandom_range(0, NUM_REQ - 1), {32'h0, $urandom}, 8'($urandom_range(0, 2)));
      run_txn($urandom_range(0, 3), -1, 1, 0, -1, 2'($urandom));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_v[i] = 1'b0;
      req_arvalid[i] = 1'b0;
    end
    tick();

    // Timeout: no R beats after the AR handshake of requester 0.
    set_req(0, 64'h0000_0000_0000_5000, 8'd0);
    tick();
    m_arready = 1'b1;
    #1;
    check_eq("tmo_ar_pulse", req_arready, 3'b001);
    tick();
    m_arready = 1'b0;
    req_arvalid[0] = 1'b0;
    pend_v[0] = 1'b0;
    for (int k = 1; k < TMO; k++) begin
      tick();
      check_eq("tmo_not_yet", timeout_err, tmo_m);
    end
    tick();
    tmo_m = 1'b1;
    check_eq("tmo_rise", timeout_err, tmo_m);
    check_eq("tmo_still_busy", busy, 1'b1);
    tick();
    check_eq("tmo_sticky", timeout_err, tmo_m);

    // Asynchronous reset mid-transaction clears everything at once.
    #2;
    rst_ni = 1'b0;
    #1;
    rid_m = 1'b0;
    tmo_m = 1'b0;
    rr_m  = 0;
    check_reset_outputs("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    set_req(0, 64'h0000_0000_0000_6000, 8'd0);
    set_req(1, 64'h0000_0000_0000_7000, 8'd0);
    set_req(2, 64'h0000_0000_0000_8000, 8'd0);
    tick();
    check_eq("post_reset_arvalid", m_arvalid, 1'b1);
    check_eq("post_reset_grant", m_arid, model_pick());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
